wb_trace_fifo: RTL and testbench
================================

# wb_trace_fifo

Write-back trace buffer downstream of the `mips` core. Captures every architectural state update the core commits, either a GRF write or a DM store, as a trace event. Holds events in a FIFO that the simulation bench or a later UART dump stage drains through a valid/ready port. Lets the bench compare committed state changes against a reference trace without probing core internals.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of the dropped-event counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ev_valid`  in  1  core commits a state update this cycle.
- `ev_kind`  in  1  0 = GRF write, 1 = DM store.
- `ev_pc`  in  32  PC of the committing instruction.
- `ev_addr`  in  32  GRF: `[4:0]` register number, upper bits ignored; DM: byte address.
- `ev_data`  in  32  value written.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_kind`  out  1  head entry kind.
- `out_pc`  out  32  head entry PC.
- `out_addr`  out  32  head entry address; GRF entries zero-extended from `[4:0]`.
- `out_data`  out  32  head entry data.
- `count`  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; set by the first dropped event.
- `drop_cnt`  out  CNT_W  number of dropped events, saturating at all-ones.

## Operation
- Filter:
  - An event with `ev_kind=0` and `ev_addr[4:0]=0` (write to $0) is discarded.
  - A filtered event is not stored and not counted as a drop.
- Push condition: `ev_valid` and event not filtered.
- Pop condition: `out_valid & out_ready`.
- Normalisation on push:
  - GRF events store `addr = {27'b0, ev_addr[4:0]}`.
  - DM events store `ev_addr` unmodified.
- Full (`count==DEPTH`):
  - Push without a same-cycle pop: event dropped, `overflow` set to 1, `drop_cnt` incremented (saturating).
  - Push with a same-cycle pop: event accepted; `count` unchanged.
- Empty (`count==0`):
  - `out_valid=0`.
  - `out_kind`, `out_pc`, `out_addr` and `out_data` read as 0.
  - `out_ready` is ignored.
- Ordering is strict FIFO.
- Pointers wrap modulo DEPTH.
- Simultaneous push and pop on a non-empty, non-full FIFO: `count` unchanged.

## Timing
- Reset (synchronous), values next cycle:
  - read/write pointers 0, `count=0`, `out_valid=0`
  - all `out_*` data fields 0, `overflow=0`, `drop_cnt=0`
- Reset has priority over a same-cycle push or pop; that event is lost and not counted.
- No fall-through: a push into an empty FIFO at edge N gives `out_valid=1` after edge N, i.e. the event is visible in cycle N+1. Push-to-output latency is 1 cycle.
- Handshake:
  - While `out_valid=1` and `out_ready=0`, all `out_*` fields hold stable.
  - `out_valid` never drops without a pop or a reset.
- `count`, `overflow` and `drop_cnt` are registered and reflect the push/pop of the previous edge.
- Sustained throughput: one push and one pop per cycle.
- `out_ready` has no combinational path to any `ev_*` input; there is no backpressure to the core.

## Structure
- Shared package/header `trace_defs`:
  - `KIND_GRF=1'b0`, `KIND_DM=1'b1`
  - entry width constant `TRACE_W=97`, packed as {kind, pc, addr, data}
- Sub-module `trace_mem`: DEPTH×TRACE_W register array, one write port and one asynchronous read port, no reset on the array.
- Pointer, count, filter and overflow logic live in `wb_trace_fifo`.

## Test plan
- Reset then push GRF event (pc=0x3000, addr=5, data=0x1234) with `out_ready=0` -> next cycle `out_valid=1`, `out_addr=5`, `out_data=0x1234`; fields hold until `out_ready=1`, after which `count` returns to 0.
- Push GRF event with `ev_addr=32'hFFFF_FFE0` (reg 0) -> no entry, `count=0`, `drop_cnt=0`. Push DM event with addr=0x0000_0004 -> stored with addr 4 and kind 1.
- 16 pushes with `out_ready=0`, then a 17th push -> `count=16`, `overflow=1`, `drop_cnt=1`. Draining then yields exactly the first 16 events in order.
- At full, push and pop in the same cycle -> `count` stays 16, `overflow` stays 0, and the new event appears last in the drain order.
- Continuous push+pop for 40 cycles (pointer wrap) -> drained sequence equals the pushed sequence, and `count` stays at 1 after the initial push.
- Assert `reset` with 7 entries stored and a push pending -> next cycle `count=0`, `out_valid=0`, all out fields 0, `overflow=0`, `drop_cnt=0`.

Source files
------------

// File: rtl/trace_defs_pkg.sv
// Shared trace-entry definitions: event kinds, entry layout and address normalisation.
package trace_defs;

    localparam logic KIND_GRF = 1'b0;
    localparam logic KIND_DM  = 1'b1;

    // Entry packed as {kind, pc, addr, data}
    localparam int TRACE_W = 97;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trace_ent_t;

    // GRF events keep only the register number; DM events keep the byte address
    function automatic logic [31:0] norm_addr(input logic kind, input logic [31:0] addr);
        return (kind == KIND_GRF) ? {27'b0, addr[4:0]} : addr;
    endfunction

    // Writes to $0 never change architectural state, so they are not traced
    function automatic logic is_filtered(input logic kind, input logic [31:0] addr);
        return (kind == KIND_GRF) && (addr[4:0] == 5'd0);
    endfunction

endpackage

// File: rtl/trace_mem.sv
// Entry storage: DEPTH x TRACE_W registers, one write port, one asynchronous read port.
module trace_mem
    import trace_defs::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [TRACE_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [TRACE_W-1:0] rdata
);

    logic [TRACE_W-1:0] mem_q [DEPTH];

    // Array is deliberately unreset; the FIFO gates the read data when empty
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/wb_trace_fifo.sv
// Commit trace FIFO: filters $0 writes, normalises GRF addresses, buffers events
// and counts drops when full. Push-to-output latency is one cycle.
module wb_trace_fifo
    import trace_defs::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ev_valid,
    input  logic                       ev_kind,
    input  logic [31:0]                ev_pc,
    input  logic [31:0]                ev_addr,
    input  logic [31:0]                ev_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_kind,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_addr,
    output logic [31:0]                out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic       push_req, push, pop, full, empty, drop;
    trace_ent_t wr_ent, rd_ent;
    logic [TRACE_W-1:0] rd_raw;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Handshake decode; a full FIFO still accepts when the head leaves this cycle
    always_comb begin
        push_req = ev_valid && !is_filtered(ev_kind, ev_addr);
        pop      = !empty && out_ready;
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        wr_ent   = '{kind: ev_kind, pc: ev_pc, addr: norm_addr(ev_kind, ev_addr), data: ev_data};
    end

    // Next-state for pointers, occupancy and drop accounting
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset wins over any same-cycle push or pop
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    trace_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (push && !reset),
        .waddr (wr_ptr_q),
        .wdata (wr_ent),
        .raddr (rd_ptr_q),
        .rdata (rd_raw)
    );

    // Head fields read as zero when empty so stale/unreset array content never leaks
    always_comb begin
        rd_ent = empty ? '0 : trace_ent_t'(rd_raw);
    end

    assign out_valid = !empty;
    assign out_kind  = rd_ent.kind;
    assign out_pc    = rd_ent.pc;
    assign out_addr  = rd_ent.addr;
    assign out_data  = rd_ent.data;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Self-checking bench for wb_trace_fifo against a queue-based reference model.
module tb_wb_trace_fifo;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;
    localparam int MAXD  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ev_valid = 1'b0, ev_kind = 1'b0;
    logic [31:0] ev_pc = '0, ev_addr = '0, ev_data = '0;
    logic        out_ready = 1'b0;
    logic        out_valid, out_kind, overflow;
    logic [31:0] out_pc, out_addr, out_data;
    logic [4:0]  count;
    logic [CNT_W-1:0] drop_cnt;

    wb_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .ev_valid(ev_valid), .ev_kind(ev_kind), .ev_pc(ev_pc), .ev_addr(ev_addr), .ev_data(ev_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_kind(out_kind), .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [96:0] mq[$];
    bit          m_ovf;
    int          m_drop;
    int          n_chk, n_bad;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [96:0] head;
        head = (mq.size() > 0) ? mq[0] : 97'd0;
        chk({tag, ".count"}, 128'(count), 128'(mq.size()));
        chk({tag, ".valid"}, 128'(out_valid), 128'(mq.size() > 0));
        chk({tag, ".head"}, 128'({out_kind, out_pc, out_addr, out_data}), 128'(head));
        chk({tag, ".ovf"}, 128'(overflow), 128'(m_ovf));
        chk({tag, ".drop"}, 128'(drop_cnt), 128'(m_drop));
    endtask

    // Apply the spec rules to the model for the inputs now on the pins, then clock and compare
    task automatic tick(input string tag);
        bit pop, push_req;
        logic [31:0] a;
        if (reset) begin
            mq.delete(); m_ovf = 0; m_drop = 0;
        end else begin
            pop      = (mq.size() > 0) && out_ready;
            push_req = ev_valid && !(ev_kind == 1'b0 && ev_addr[4:0] == 5'd0);
            if (pop) void'(mq.pop_front());
            if (push_req) begin
                a = (ev_kind == 1'b0) ? (ev_addr & 32'h1f) : ev_addr;
                if (mq.size() < DEPTH) mq.push_back({ev_kind, ev_pc, a, ev_data});
                else begin
                    m_ovf = 1;
                    if (m_drop < MAXD) m_drop++;
                end
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit v, input bit k, input logic [31:0] pc, input logic [31:0] ad,
                         input logic [31:0] d, input bit rdy);
        ev_valid = v; ev_kind = k; ev_pc = pc; ev_addr = ad; ev_data = d; out_ready = rdy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick("reset");
        reset = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_bad = 0; m_ovf = 0; m_drop = 0;
        #1;
        do_reset();

        // single GRF push, held while not ready, then drained
        drive(1, 0, 32'h3000, 32'd5, 32'h1234, 0); tick("grf_push");
        chk("grf_addr", 128'(out_addr), 128'd5);
        chk("grf_data", 128'(out_data), 128'h1234);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick("hold");
        out_ready = 1; tick("drain1");
        chk("drain1_cnt", 128'(count), 128'd0);

        // filtered $0 write, then DM store
        drive(1, 0, 32'h3004, 32'hFFFF_FFE0, 32'hdead, 0); tick("filt");
        chk("filt_cnt", 128'(count), 128'd0);
        drive(1, 1, 32'h3008, 32'h4, 32'hbeef, 0); tick("dm_push");
        chk("dm_kind", 128'(out_kind), 128'd1);
        chk("dm_addr", 128'(out_addr), 128'd4);
        drive(0, 0, 0, 0, 0, 1); tick("dm_drain");

        // overflow: 17 pushes with no consumer, then drain
        for (int i = 0; i < 17; i++) begin
            drive(1, 1, 32'h4000 + 32'(i * 4), 32'h100 + 32'(i), 32'(i * 7 + 1), 0);
            tick("fill");
        end
        chk("ovf_flag", 128'(overflow), 128'd1);
        chk("ovf_drop", 128'(drop_cnt), 128'd1);
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 17; i++) tick("ovf_drain");

        // push+pop at full is accepted
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 32'h5000 + 32'(i), 32'(i + 1), 32'(i), 0);
            tick("fill2");
        end
        drive(1, 1, 32'h6000, 32'h80, 32'hcafe, 1); tick("full_pp");
        chk("full_pp_cnt", 128'(count), 128'd16);
        chk("full_pp_ovf", 128'(overflow), 128'd0);
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 17; i++) tick("full_drain");

        // continuous push+pop through pointer wrap
        do_reset();
        for (int i = 0; i < 40; i++) begin
            drive(1, 1, 32'h7000 + 32'(i), 32'h200 + 32'(i), $urandom, 1);
            tick("stream");
            chk("stream_cnt", 128'(count), 128'd1);
        end
        drive(0, 0, 0, 0, 0, 1); tick("stream_end");

        // reset with entries held and a push pending
        for (int i = 0; i < 7; i++) begin
            drive(1, 0, 32'h8000, 32'(i + 1), 32'(i), 0);
            tick("pre_rst");
        end
        drive(1, 1, 32'h9000, 32'h10, 32'h55, 1);
        reset = 1'b1; tick("rst_busy"); reset = 1'b0;
        chk("rst_pc", 128'(out_pc), 128'd0);

        // randomized traffic: low-ready phase to hit full, then high-ready phase
        for (int i = 0; i < 600; i++) begin
            ev_valid  = ($urandom_range(0, 3) != 0);
            ev_kind   = 1'($urandom);
            ev_pc     = $urandom;
            ev_addr   = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFE0) : $urandom;
            ev_data   = $urandom;
            out_ready = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
